// File: rtl/fir_pkg.sv
// ============================================================================
// Module : fir_pkg
// Shared FSM state type, default widths and width helpers for the FIR MAC.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int DEF_N_TAPS    = 4;
  localparam int DEF_BW_IN     = 2;
  localparam int DEF_BW_COEF   = 3;
  localparam int DEF_BW_ACC    = 8;
  localparam int DEF_BW_OUT    = 3;
  localparam int DEF_OUT_SHIFT = 0;

  function automatic int prod_width(input int bw_in, input int bw_coef);
    return bw_in + bw_coef;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_mac.sv
// ============================================================================
// Module : fir_mac
// Shared signed multiply-accumulate with output slice; FIR_SAT_EN clamps it.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_mac
  import fir_pkg::*;
#(
  parameter int BW_IN     = DEF_BW_IN,
  parameter int BW_COEF   = DEF_BW_COEF,
  parameter int BW_ACC    = DEF_BW_ACC,
  parameter int BW_OUT    = DEF_BW_OUT,
  parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      en,
  input  logic                      last,
  input  logic signed [BW_COEF-1:0] coef,
  input  logic signed [BW_IN-1:0]   sample,
  output logic signed [BW_OUT-1:0]  y
);

  localparam int PW  = prod_width(BW_IN, BW_COEF);
  localparam int MSB = OUT_SHIFT + BW_OUT - 1;

  logic signed [PW-1:0]     prod;
  logic signed [BW_ACC-1:0] prod_ext;
  logic signed [BW_ACC-1:0] acc;
  logic signed [BW_ACC-1:0] acc_next;
  logic signed [BW_OUT-1:0] y_next;

  assign prod     = PW'(coef) * PW'(sample);
  assign prod_ext = BW_ACC'(prod);
  assign acc_next = acc + prod_ext;

`ifdef FIR_SAT_EN
  // Clamp when the discarded upper bits are not a pure sign extension of the slice.
  logic [BW_ACC-MSB-1:0] upper;
  assign upper = acc_next[BW_ACC-1:MSB];

  always_comb begin
    y_next = acc_next[MSB:OUT_SHIFT];
    if (!((&upper) || (~|upper))) begin
      y_next = acc_next[BW_ACC-1] ? {1'b1, {(BW_OUT-1){1'b0}}}
                                  : {1'b0, {(BW_OUT-1){1'b1}}};
    end
  end
`else
  assign y_next = acc_next[MSB:OUT_SHIFT];
`endif

  // Output is captured from the final sum so it is already valid during the strobe cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      y   <= '0;
    end else begin
      if (clear)
        acc <= '0;
      else if (en)
        acc <= acc_next;
      if (en && last)
        y <= y_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
// ============================================================================
// Module : fir_mac_sequencer
// Time-multiplexed FIR: FSM, delay line and coefficient bank around fir_mac.
// Optional macro FIR_SAT_EN selects a saturating output slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int N_TAPS    = DEF_N_TAPS,
  parameter int BW_IN     = DEF_BW_IN,
  parameter int BW_COEF   = DEF_BW_COEF,
  parameter int BW_ACC    = DEF_BW_ACC,
  parameter int BW_OUT    = DEF_BW_OUT,
  parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [BW_IN-1:0]   x_in,
  input  logic                      coef_load,
  input  logic signed [BW_COEF-1:0] coef_data,
  output logic                      out_valid,
  output logic signed [BW_OUT-1:0]  y_out,
  output logic                      busy
);

  localparam int            KW     = $clog2(N_TAPS);
  localparam logic [KW-1:0] K_LAST = KW'(N_TAPS - 1);

  state_t                    state;
  state_t                    state_next;
  logic [KW-1:0]             k;
  logic signed [BW_IN-1:0]   taps  [N_TAPS];
  logic signed [BW_COEF-1:0] coefs [N_TAPS];
  logic                      hs;
  logic                      load_en;
  logic                      mac_en;
  logic                      k_last;

  assign k_last = (k == K_LAST);

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    hs         = 1'b0;
    load_en    = 1'b0;
    mac_en     = 1'b0;
    case (state)
      IDLE: begin
        // A coefficient load takes priority over an incoming sample.
        in_ready = !coef_load;
        load_en  = coef_load;
        hs       = in_valid && !coef_load;
        if (hs)
          state_next = MAC;
      end
      MAC: begin
        busy   = 1'b1;
        mac_en = 1'b1;
        if (k_last)
          state_next = OUT;
      end
      OUT: begin
        busy       = 1'b1;
        out_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k <= '0;
      for (int i = 0; i < N_TAPS; i++) begin
        taps[i]  <= '0;
        coefs[i] <= '0;
      end
    end else begin
      if (hs) begin
        k       <= '0;
        taps[0] <= x_in;
        for (int i = 1; i < N_TAPS; i++)
          taps[i] <= taps[i-1];
      end else if (mac_en) begin
        k <= k_last ? '0 : k + 1'b1;
      end
      if (load_en) begin
        coefs[0] <= coef_data;
        for (int i = 1; i < N_TAPS; i++)
          coefs[i] <= coefs[i-1];
      end
    end
  end

  fir_mac #(
    .BW_IN     (BW_IN),
    .BW_COEF   (BW_COEF),
    .BW_ACC    (BW_ACC),
    .BW_OUT    (BW_OUT),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clear  (hs),
    .en     (mac_en),
    .last   (k_last),
    .coef   (coefs[k]),
    .sample (taps[k]),
    .y      (y_out)
  );

endmodule

`default_nettype wire

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Time-multiplexed FIR controller: one shared multiply-accumulate unit is sequenced over N_TAPS stored samples and run-time loadable coefficients.
- Sits between the serial sample source and the output pins.
- Adds a valid/ready sample handshake, a serial coefficient-load path and an output-valid strobe.
- Replaces the fixed-coefficient, fully parallel tap arithmetic.

Parameters:
- N_TAPS, 4, number of taps (≥2); length of the delay line and coefficient bank.
- BW_IN, 2, signed input sample width.
- BW_COEF, 3, signed coefficient width.
- BW_ACC, 8, signed accumulator width; must be ≥ BW_IN+BW_COEF.
- BW_OUT, 3, signed output width.
- OUT_SHIFT, 0, LSB index of the accumulator slice driven to y_out.

Ports:
- clk  in  1  clock.
- reset  in  1  reset: synchronous, active-high.
- in_valid  in  1  x_in is valid.
- in_ready  out  1  block accepts a sample this cycle.
- x_in  in  BW_IN  signed sample.
- coef_load  in  1  shift coef_data into the coefficient bank.
- coef_data  in  BW_COEF  signed coefficient.
- out_valid  out  1  one-cycle strobe; y_out is updated this cycle.
- y_out  out  BW_OUT  signed filter output; holds between strobes.
- busy  out  1  high in MAC and OUT states.

Behaviour:
- Reset: state IDLE; delay line, coefficients, accumulator, tap index and y_out all 0; out_valid 0; in_ready 1 unless coef_load is high.
- Reset mid-operation: the computation is aborted and no out_valid is produced.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_ready = !coef_load.
  - Handshake occurs when in_valid && in_ready.
  - On handshake: tap[0] <= x_in and tap[k] <= tap[k-1]; acc <= 0; k <= 0; next state MAC.
- MAC, one tap per cycle:
  - acc <= acc + sext(coef[k]*tap[k]).
  - Product is signed, BW_IN+BW_COEF wide, sign-extended to BW_ACC.
  - k increments each cycle; after the cycle with k = N_TAPS-1, next state is OUT.
  - acc wraps modulo 2^BW_ACC.
- OUT:
  - y_out <= slice acc[OUT_SHIFT+BW_OUT-1:OUT_SHIFT]; out_valid = 1 for exactly this cycle.
  - Next state IDLE.
- Timing:
  - Handshake in cycle T gives out_valid in cycle T+N_TAPS+1.
  - Maximum throughput is one sample per N_TAPS+2 cycles.
  - in_ready is 0 in MAC and OUT.
- Coefficient load:
  - Acts only in IDLE: coef[0] <= coef_data and coef[k] <= coef[k-1]. The last-loaded value becomes coef[0], which applies to the newest sample.
  - coef_load in MAC or OUT is ignored; the bank is unchanged.
  - coef_load and in_valid together in IDLE: the load wins, and in_ready = 0 that cycle.
- in_valid while not ready: no effect; the source holds x_in until the handshake.

Optional Feature:
- FIR_SAT_EN defined: if the acc bits above the slice MSB are not all equal to the slice MSB, y_out clamps to 2^(BW_OUT-1)-1 (acc ≥ 0) or -2^(BW_OUT-1) (acc < 0). Bits below OUT_SHIFT are truncated.
- FIR_SAT_EN undefined: plain slice; upper bits are discarded (wrap).

Decomposition:
- Package fir_pkg holds:
  - State enum (IDLE/MAC/OUT).
  - Default width constants.
  - Helper function for the product width (BW_IN+BW_COEF).
- Sub-module fir_mac holds the signed multiplier, sign extension, accumulator register with clear/enable, and the output slice/saturation logic.
- The top level keeps the FSM, tap counter, delay line and coefficient bank.

Test Plan (default parameters):
- Reset, then idle 10 cycles -> y_out=0, out_valid=0, in_ready=1, busy=0; any sample gives output 0 (coefficients cleared).
- Load coefficients 0,0,2,1 (coef[0]=1, coef[1]=2); send x=1,1,-1 -> out_valid 5 cycles after each handshake; y_out = 1, 3, 1.
- Assert in_valid continuously -> in_ready pulses once every 6 cycles; exactly one out_valid per accepted sample; no samples lost or duplicated.
- Assert coef_load during MAC -> bank unchanged, output matches the previous coefficients. Assert coef_load with in_valid in IDLE -> the load happens, no handshake that cycle.
- Coefficients all 3; send x=1 four times -> fourth acc=12 -> y_out=-4 without FIR_SAT_EN, y_out=3 with it. Coefficients all -4, x=1 four times -> acc=-16 -> y_out=0 (wrap) or -4 (sat).
- Assert reset two cycles into MAC -> no out_valid, y_out=0, state IDLE, delay line and coefficients cleared.
